// File: rtl/adder_axis_rr_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: defaults, ID width helper
// and FSM state encoding.
package adder_axis_rr_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/adder_axis_rr_arbiter_tag_fifo.sv
// In-order tag FIFO holding requester IDs of sums in flight through the shared adder.
// Pointers carry an extra wrap bit so full and empty can be told apart.
module adder_axis_rr_arbiter_tag_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adder_axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream two-operand adder among N_REQ requesters;
// results return tagged with the originating requester ID via an in-order tag FIFO.
module adder_axis_rr_arbiter
  import adder_axis_rr_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int TAG_DEPTH = 4,
  parameter int ID_W      = id_width(N_REQ)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [N_REQ*WIDTH-1:0] req_tdata1,
  input  logic [N_REQ*WIDTH-1:0] req_tdata2,
  input  logic [N_REQ-1:0]   req_tvalid,
  output logic [N_REQ-1:0]   req_tready,
  output logic [WIDTH-1:0]   add1_tdata,
  output logic               add1_tvalid,
  input  logic               add1_tready,
  output logic [WIDTH-1:0]   add2_tdata,
  output logic               add2_tvalid,
  input  logic               add2_tready,
  input  logic [WIDTH:0]     sum_tdata,
  input  logic               sum_tvalid,
  output logic               sum_tready,
  output logic [WIDTH:0]     rsp_tdata,
  output logic [ID_W-1:0]    rsp_tdest,
  output logic               rsp_tvalid,
  input  logic               rsp_tready,
  output logic               busy
);

  state_t          state;
  state_t          state_next;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] head;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic            sent1;
  logic            sent2;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            can_push;

  // First set request bit strictly after 'last', wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 32'(N_REQ); i++) begin
      idx = (32'(last) + i) % 32'(N_REQ);
      if (!found && req[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign rsp_tdata  = sum_tdata;
  assign rsp_tdest  = head;
  assign rsp_tvalid = sum_tvalid && !empty;
  assign sum_tready = rsp_tready && !empty;
  assign pop        = rsp_tvalid && rsp_tready;
  assign can_push   = !full || pop;

  assign add1_tdata = op1;
  assign add2_tdata = op2;
  assign busy       = (state == ISSUE) || !empty;

  always_comb begin
    state_next  = state;
    req_tready  = '0;
    push        = 1'b0;
    add1_tvalid = 1'b0;
    add2_tvalid = 1'b0;
    grant       = rr_pick(req_tvalid, last_grant);
    case (state)
      IDLE: begin
        if (|req_tvalid && can_push) begin
          req_tready[grant] = 1'b1;
          push              = 1'b1;
          state_next        = ISSUE;
        end
      end
      ISSUE: begin
        add1_tvalid = !sent1;
        add2_tvalid = !sent2;
        if ((sent1 || add1_tready) && (sent2 || add2_tready)) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ - 1);
      op1        <= '0;
      op2        <= '0;
      sent1      <= 1'b0;
      sent2      <= 1'b0;
    end else begin
      state <= state_next;
      if (push) begin
        op1        <= req_tdata1[32'(grant)*WIDTH +: WIDTH];
        op2        <= req_tdata2[32'(grant)*WIDTH +: WIDTH];
        last_grant <= grant;
        sent1      <= 1'b0;
        sent2      <= 1'b0;
      end else begin
        if (add1_tvalid && add1_tready) sent1 <= 1'b1;
        if (add2_tvalid && add2_tready) sent2 <= 1'b1;
      end
    end
  end

  adder_axis_rr_arbiter_tag_fifo #(
    .DEPTH  (TAG_DEPTH),
    .DATA_W (ID_W)
  ) u_tag_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .din   (grant),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_adder_axis_rr_arbiter.sv
// Bench for adder_axis_rr_arbiter: plays requesters, the shared adder and the response
// sink, and compares every cycle against a transaction-level reference model.
module tb_adder_axis_rr_arbiter;

  localparam int N_REQ     = 4;
  localparam int WIDTH     = 8;
  localparam int TAG_DEPTH = 4;
  localparam int ID_W      = 2;

  logic                   aclk = 1'b0;
  logic                   aresetn;
  logic [N_REQ*WIDTH-1:0] req_tdata1, req_tdata2;
  logic [N_REQ-1:0]       req_tvalid, req_tready;
  logic [WIDTH-1:0]       add1_tdata, add2_tdata;
  logic                   add1_tvalid, add1_tready, add2_tvalid, add2_tready;
  logic [WIDTH:0]         sum_tdata;
  logic                   sum_tvalid, sum_tready;
  logic [WIDTH:0]         rsp_tdata;
  logic [ID_W-1:0]        rsp_tdest;
  logic                   rsp_tvalid, rsp_tready, busy;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  adder_axis_rr_arbiter #(
    .N_REQ     (N_REQ),
    .WIDTH     (WIDTH),
    .TAG_DEPTH (TAG_DEPTH)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_tdata1  (req_tdata1),
    .req_tdata2  (req_tdata2),
    .req_tvalid  (req_tvalid),
    .req_tready  (req_tready),
    .add1_tdata  (add1_tdata),
    .add1_tvalid (add1_tvalid),
    .add1_tready (add1_tready),
    .add2_tdata  (add2_tdata),
    .add2_tvalid (add2_tvalid),
    .add2_tready (add2_tready),
    .sum_tdata   (sum_tdata),
    .sum_tvalid  (sum_tvalid),
    .sum_tready  (sum_tready),
    .rsp_tdata   (rsp_tdata),
    .rsp_tdest   (rsp_tdest),
    .rsp_tvalid  (rsp_tvalid),
    .rsp_tready  (rsp_tready),
    .busy        (busy)
  );

  // Reference model: expected in-flight transactions, the operands still owed to the
  // adder, and the bench-side adder's operand and result queues.
  typedef struct { int id; int a; int b; } txn_t;
  txn_t inflight[$];
  int   q1[$], q2[$], sums[$];
  int   last_id;
  bit   issuing, need1, need2;
  int   cur_a, cur_b;
  bit   spurious;
  int   obs_grants;
  bit   obs_granted;
  int   obs_rsp_data, obs_rsp_dest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    inflight.delete(); q1.delete(); q2.delete(); sums.delete();
    last_id = N_REQ - 1;
    issuing = 0; need1 = 0; need2 = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    req_tvalid = '0; sum_tvalid = 1'b0; sum_tdata = '0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_clear();
  endtask

  // One clock cycle: present adder results, check every output against the model,
  // commit the handshakes the model predicts, then cross the clock edge.
  task automatic step();
    int          granted;
    bit          do_pop;
    logic [N_REQ-1:0] exp_ready;
    @(negedge aclk);
    if (sums.size() > 0) begin
      sum_tvalid = 1'b1; sum_tdata = (WIDTH+1)'(sums[0]);
    end else if (spurious) begin
      sum_tvalid = 1'b1; sum_tdata = '1;
    end else begin
      sum_tvalid = 1'b0; sum_tdata = '0;
    end
    #1;
    do_pop = rsp_tready && sum_tvalid && (inflight.size() > 0);
    chk("busy", 32'(busy), 32'(issuing || inflight.size() > 0));
    chk("rsp_tvalid", 32'(rsp_tvalid), 32'(sum_tvalid && inflight.size() > 0));
    chk("sum_tready", 32'(sum_tready), 32'(rsp_tready && inflight.size() > 0));
    if (sum_tvalid && inflight.size() > 0) begin
      chk("rsp_tdest", 32'(rsp_tdest), inflight[0].id);
      chk("rsp_tdata", 32'(rsp_tdata), inflight[0].a + inflight[0].b);
    end
    chk("add1_tvalid", 32'(add1_tvalid), 32'(need1));
    chk("add2_tvalid", 32'(add2_tvalid), 32'(need2));
    if (need1) chk("add1_tdata", 32'(add1_tdata), cur_a);
    if (need2) chk("add2_tdata", 32'(add2_tdata), cur_b);

    granted   = -1;
    exp_ready = '0;
    if (!issuing && req_tvalid != '0 && (inflight.size() < TAG_DEPTH || do_pop)) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (granted < 0 && req_tvalid[(last_id + k) % N_REQ]) granted = (last_id + k) % N_REQ;
      end
      exp_ready[granted] = 1'b1;
    end
    chk("req_tready", 32'(req_tready), 32'(exp_ready));

    obs_granted = ((req_tready & req_tvalid) != '0);
    if (obs_granted) obs_grants++;
    if (rsp_tvalid && rsp_tready) begin
      obs_rsp_data = int'(rsp_tdata);
      obs_rsp_dest = int'(rsp_tdest);
    end

    if (do_pop) begin
      void'(inflight.pop_front());
      void'(sums.pop_front());
    end
    if (issuing) begin
      if (need1 && add1_tready) begin q1.push_back(cur_a); need1 = 0; end
      if (need2 && add2_tready) begin q2.push_back(cur_b); need2 = 0; end
      if (!need1 && !need2) issuing = 0;
    end
    while (q1.size() > 0 && q2.size() > 0) sums.push_back(q1.pop_front() + q2.pop_front());
    if (granted >= 0) begin
      cur_a = int'(req_tdata1[granted*WIDTH +: WIDTH]);
      cur_b = int'(req_tdata2[granted*WIDTH +: WIDTH]);
      inflight.push_back('{granted, cur_a, cur_b});
      last_id = granted;
      issuing = 1; need1 = 1; need2 = 1;
    end
    @(posedge aclk);
    #1;
    if (granted >= 0) begin
      req_tdata1[granted*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_tdata2[granted*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
  endtask

  task automatic drain(input int n);
    req_tvalid = '0; add1_tready = 1'b1; add2_tready = 1'b1; rsp_tready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    int g0;
    aresetn = 1'b0;
    req_tdata1 = '0; req_tdata2 = '0; req_tvalid = '0;
    add1_tready = 1'b0; add2_tready = 1'b0; rsp_tready = 1'b0;
    sum_tvalid = 1'b0; sum_tdata = '0; spurious = 0;
    obs_grants = 0; obs_rsp_data = -1; obs_rsp_dest = -1;
    model_clear();
    do_reset();
    step();

    // Single requester 1 sends (5,7).
    add1_tready = 1'b1; add2_tready = 1'b1; rsp_tready = 1'b1;
    req_tdata1[1*WIDTH +: WIDTH] = 8'd5;
    req_tdata2[1*WIDTH +: WIDTH] = 8'd7;
    req_tvalid = 4'b0010;
    step();
    req_tvalid = '0;
    repeat (5) step();
    chk("single_rsp_data", obs_rsp_data, 12);
    chk("single_rsp_dest", obs_rsp_dest, 1);

    // All requesters valid: round robin order, including the 255+255 corner.
    for (int i = 0; i < N_REQ; i++) begin
      req_tdata1[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_tdata2[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    req_tdata1[0 +: WIDTH] = 8'd255;
    req_tdata2[0 +: WIDTH] = 8'd255;
    req_tvalid = '1;
    repeat (24) step();
    drain(8);

    // Adder inputs accept three cycles apart: exactly one grant.
    g0 = obs_grants;
    add1_tready = 1'b0; add2_tready = 1'b0;
    req_tvalid = 4'b0100;
    step();
    req_tvalid = '0;
    step();
    add1_tready = 1'b1; step();
    add1_tready = 1'b0; step(); step();
    add2_tready = 1'b1; step();
    repeat (4) step();
    chk("skew_grants", obs_grants - g0, 1);
    drain(4);

    // Response backpressure: FIFO fills at TAG_DEPTH, then push and pop coincide.
    g0 = obs_grants;
    rsp_tready = 1'b0;
    req_tvalid = '1;
    repeat (20) step();
    chk("bp_grants", obs_grants - g0, TAG_DEPTH);
    rsp_tready = 1'b1;
    step();
    chk("full_pushpop_grant", 32'(obs_granted), 1);
    repeat (20) step();
    drain(12);

    // Reset while add2 is still pending.
    add1_tready = 1'b1; add2_tready = 1'b0;
    req_tvalid = 4'b1000;
    step();
    req_tvalid = '0;
    step();
    do_reset();
    add2_tready = 1'b1;
    step();
    req_tvalid = 4'b1010;
    step();
    req_tvalid = '0;
    repeat (6) step();
    chk("post_reset_dest", obs_rsp_dest, 1);

    // Stray adder result with no tag in flight must not surface.
    spurious = 1;
    repeat (3) step();
    spurious = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req_tvalid  = N_REQ'($urandom);
      add1_tready = ($urandom_range(0, 3) != 0);
      add2_tready = ($urandom_range(0, 3) != 0);
      rsp_tready  = ($urandom_range(0, 2) != 0);
      step();
    end
    drain(20);
    chk("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_axis_rr_arbiter.md
Name: adder_axis_rr_arbiter

Overview:
Shares one AXI-Stream two-operand adder among N_REQ requesters. Each requester presents one operand pair per beat. The block grants requesters round-robin, splits each granted pair onto the adder's two independent input streams and records the requester ID in an in-order tag FIFO. Adder results return on a single response stream tagged with the originating requester ID (tdest). It sits between requester logic and the shared adder instance.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, operand width; result width is WIDTH+1
TAG_DEPTH, 4, depth of the in-flight tag FIFO (power of 2, ≥2); limits outstanding sums
ID_W, $clog2(N_REQ), requester ID width (derived; not overridden)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
req_tdata1  in  N_REQ*WIDTH  operand 1 per requester, packed; requester i occupies [i*WIDTH +: WIDTH]
req_tdata2  in  N_REQ*WIDTH  operand 2 per requester, packed the same way
req_tvalid  in  N_REQ  operand-pair valid, one bit per requester
req_tready  out  N_REQ  operand-pair accept, one-hot or zero
add1_tdata  out  WIDTH  to adder input 1
add1_tvalid  out  1
add1_tready  in  1
add2_tdata  out  WIDTH  to adder input 2
add2_tvalid  out  1
add2_tready  in  1
sum_tdata  in  WIDTH+1  adder result
sum_tvalid  in  1
sum_tready  out  1
rsp_tdata  out  WIDTH+1  tagged result
rsp_tdest  out  ID_W  requester ID of the result
rsp_tvalid  out  1
rsp_tready  in  1
busy  out  1  high in ISSUE or when the tag FIFO is non-empty

Behaviour:
- Reset (aresetn=0 at posedge): state=IDLE; last_grant=N_REQ-1; tag FIFO empty; sent1=sent2=0.
- Reset outputs: req_tready=0, add1_tvalid=add2_tvalid=0, rsp_tvalid=0, sum_tready=0, busy=0.
- Reset mid-operation discards held operands and all tags. The shared adder must use the same aresetn.
- FSM, two states:
  - IDLE:
    - If |req_tvalid and the tag FIFO is not full, grant g = first set req_tvalid bit searching from last_grant+1, wrapping modulo N_REQ.
    - Assert req_tready[g] combinationally in the same cycle; the handshake completes in that cycle.
    - At the clock edge: capture operands into op1/op2, push g into the tag FIFO, set last_grant=g, clear sent1/sent2, go to ISSUE.
    - If the FIFO is full, or no request is valid, req_tready=0 and the FSM stays in IDLE.
  - ISSUE:
    - add1_tvalid=!sent1 with add1_tdata=op1; add2_tvalid=!sent2 with add2_tdata=op2. tdata holds stable while tvalid is high.
    - add1 handshake sets sent1; add2 handshake sets sent2. Either may complete first or both in the same cycle.
    - When both are complete (flags or current handshakes), go to IDLE at that edge.
    - req_tready=0 throughout ISSUE.
- Grant-to-adder latency: at least 1 cycle. At most one grant per 2 cycles (IDLE→ISSUE→IDLE).
- Response path is combinational pass-through:
  - rsp_tdata=sum_tdata; rsp_tdest=FIFO head; rsp_tvalid=sum_tvalid & !empty; sum_tready=rsp_tready & !empty.
  - A rsp handshake pops the FIFO.
- Push and pop in the same cycle: occupancy unchanged. A push is allowed when full only if a pop occurs in that cycle; the FIFO must not under- or overflow.
- sum_tvalid with an empty FIFO is a protocol error. Hold sum_tready=0; no spurious response.
- Fairness: a requester holding req_tvalid is granted within N_REQ grants.
- No arithmetic inside the block; widths pass through unchanged.

Decomposition:
- Shared package/include: WIDTH default, N_REQ default, ID_W computation, the FSM state encoding (IDLE=1'b0, ISSUE=1'b1).
- One sub-module: tag_fifo, a synchronous FIFO with parameters DEPTH and DATA_W, outputs full/empty, and registered pointers carrying an extra wrap bit.
- The round-robin picker stays inline as a function.

Test Plan:
- Single requester: req1 sends (5,7) with adder ready constantly → add1/add2 carry 5/7 the cycle after grant; response rsp_tdata=12, rsp_tdest=1.
- Fairness: all 4 requesters continuously valid → grant order 0,1,2,3,0,…; rsp_tdest sequence matches; each sum equals op1+op2. Include (255,255) → 510.
- Skewed adder ready: add1_tready high at cycle t, add2_tready high at cycle t+3 → add1_tvalid drops after t, add2_tvalid stays high until t+3, then IDLE; exactly one tag pushed.
- Backpressure: rsp_tready=0 for 20 cycles with TAG_DEPTH=4 → exactly 4 grants, then req_tready stays 0. On release, 4 responses come out in grant order, then granting resumes.
- Simultaneous push/pop at full: FIFO full, rsp handshake in the same cycle as an IDLE grant → grant accepted and occupancy stays 4.
- Reset mid-ISSUE: aresetn=0 for 1 cycle with add2 pending → all valids and readies 0, busy=0, and the next transaction gets a correct tag.
